// File: rtl/mux_pkg.sv
// Shared constants and types for the 4-way demux datapath.
package mux_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_CHAN = 4;
  localparam logic [7:0] CNT_MAX = 8'hFF;

  typedef logic [1:0] chan_idx_t;

endpackage

// File: rtl/demux_4_reg_slot.sv
// One-entry holding slot for a demux channel, with an optional saturating
// delivery counter when DEMUX_STATS_EN is defined.
module demux_slot
  import mux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q
`ifdef DEMUX_STATS_EN
  ,
  output logic [7:0]       cnt
`endif
);

  logic drain;
  assign drain = valid && ready;

  // NOTE: state registers use non-blocking assignments so every slot samples
  // the same pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      // A load wins over a drain in the same cycle, keeping the slot FULL.
      valid <= 1'b1;
      q     <= data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

`ifdef DEMUX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (drain && cnt != CNT_MAX) begin
      cnt <= cnt + 8'd1;
    end
  end
`endif

endmodule

// File: rtl/demux_4_reg.sv
// Registered 1-to-4 demux with per-channel valid/ready slots.
// Define DEMUX_STATS_EN to add the xfer_cnt per-channel delivery counters.
module demux_4_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [31:0]      xfer_cnt
`endif
);

  chan_idx_t        sel;
  logic             accept;
  logic [3:0]       load;
  logic [WIDTH-1:0] q [NUM_CHAN];

  assign sel      = {s1, s0};
  assign in_ready = !out_valid[sel] || out_ready[sel];
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: default first so every path assigns load and no latch is inferred.
    load      = '0;
    load[sel] = accept;
  end

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[i]),
      .data  (in_data),
      .ready (out_ready[i]),
      .valid (out_valid[i]),
      .q     (q[i])
`ifdef DEMUX_STATS_EN
      ,
      .cnt   (xfer_cnt[8*i +: 8])
`endif
    );
  end

  assign out0 = q[0];
  assign out1 = q[1];
  assign out2 = q[2];
  assign out3 = q[3];

endmodule

// File: tb/tb_demux_4_reg.sv
// Directed self-checking bench for demux_4_reg; covers the stats counters
// when DEMUX_STATS_EN is defined.
module tb_demux_4_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       s0, s1;
  logic [7:0] out0, out1, out2, out3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
`ifdef DEMUX_STATS_EN
  logic [31:0] xfer_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_4_reg #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s0        (s0),
    .s1        (s1),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX_STATS_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] out_of(input int ch);
    case (ch)
      0:       return out0;
      1:       return out1;
      2:       return out2;
      default: return out3;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [1:0] ch, input logic [7:0] d);
    in_valid = v;
    {s1, s0} = ch;
    in_data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] route_ch [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
  logic [7:0] route_d  [4] = '{8'h00, 8'hAA, 8'hFF, 8'h55};

  initial begin
    rst_n = 1'b0;
    out_ready = 4'b0000;
    drive(1'b0, 2'd0, 8'h00);
    #3;
    check("rst_valid", out_valid, 4'b0000);
    check("rst_outs", {out3, out2, out1, out0}, 32'h0);
    check("rst_in_ready", in_ready, 1'b1);
`ifdef DEMUX_STATS_EN
    check("rst_cnt", xfer_cnt, 32'h0);
`endif
    #4 rst_n = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 1'b1);
    check("idle_valid", out_valid, 4'b0000);

    // Routing with all destinations ready.
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, route_ch[i], route_d[i]);
      tick();
      check($sformatf("route%0d_valid", i), out_valid, 4'b0001 << route_ch[i]);
      check($sformatf("route%0d_data", i), out_of(int'(route_ch[i])), route_d[i]);
    end
    drive(1'b0, 2'd0, 8'h00);
    tick();
    check("route_drained", out_valid, 4'b0000);

    // Back-pressure on channel 1.
    out_ready = 4'b1101;
    drive(1'b1, 2'd1, 8'hAA);
    tick();
    check("bp_valid", out_valid, 4'b0010);
    check("bp_out1", out1, 8'hAA);
    drive(1'b1, 2'd1, 8'h33);
    #1;
    check("bp_in_ready_low", in_ready, 1'b0);
    tick();
    check("bp_hold_out1", out1, 8'hAA);
    check("bp_hold_valid", out_valid, 4'b0010);
    out_ready = 4'b1111;
    #1;
    check("bp_in_ready_high", in_ready, 1'b1);
    tick();
    check("bp_nobubble_out1", out1, 8'h33);
    check("bp_nobubble_valid", out_valid, 4'b0010);
    drive(1'b0, 2'd0, 8'h00);
    tick();
    check("bp_drained", out_valid, 4'b0000);

    // Channel 2 stalled while channel 0 receives data.
    out_ready = 4'b1011;
    drive(1'b1, 2'd2, 8'h77);
    tick();
    drive(1'b1, 2'd0, 8'h55);
    #1;
    check("ind_in_ready", in_ready, 1'b1);
    tick();
    check("ind_out0", out0, 8'h55);
    check("ind_valid", out_valid, 4'b0101);
    drive(1'b0, 2'd0, 8'h00);
    tick();
    check("ind_valid_after", out_valid, 4'b0100);
    check("ind_out2", out2, 8'h77);

    // Asynchronous reset while slots are full.
    out_ready = 4'b0000;
    drive(1'b1, 2'd0, 8'h11);
    tick();
    drive(1'b1, 2'd3, 8'h99);
    tick();
    drive(1'b0, 2'd0, 8'h00);
    check("pre_rst_valid", out_valid, 4'b1101);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 4'b0000);
    check("async_rst_outs", {out3, out2, out1, out0}, 32'h0);
    #1 rst_n = 1'b1;
    tick();

`ifdef DEMUX_STATS_EN
    check("cnt_after_rst", xfer_cnt, 32'h0);
    out_ready = 4'b1111;
    // 260 back-to-back words to channel 3: 259 drains while streaming plus one.
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 2'd3, i[7:0]);
      tick();
    end
    drive(1'b0, 2'd0, 8'h00);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd1, 8'hC0 + i[7:0]);
      tick();
    end
    drive(1'b0, 2'd0, 8'h00);
    tick();
    check("cnt_sat", xfer_cnt, 32'hFF00_0300);
    check("cnt_valid_idle", out_valid, 4'b0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
